// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller: fetches a block for the I- or D-cache with pipelined word reads,
// streams the words into the cache, writes the tag, and serialises write-through stores.
module cache_fill_ctrl #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic [2:0]        fill_word,
  output logic [15:0]       fill_data,
  output logic              tag_we_i,
  output logic              tag_we_d,
  output logic [ADDR_W-1:0] fill_base,
  output logic              wr_done,
  output logic              busy
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(WORDS_PER_BLOCK);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(WORDS_PER_BLOCK - 1);
  // Byte offset within a block: 2 bytes per word
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state_r, stateNext_s;
  logic              reqD_r, reqDNext_s;
  logic [ADDR_W-1:0] fillBase_r, fillBaseNext_s;
  logic [IDX_W:0]    issueCnt_r, issueCntNext_s;
  logic [IDX_W:0]    recvCnt_r, recvCntNext_s;

  // State, requester and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      reqD_r     <= 1'b0;
      fillBase_r <= '0;
      issueCnt_r <= '0;
      recvCnt_r  <= '0;
    end else begin
      state_r    <= stateNext_s;
      reqD_r     <= reqDNext_s;
      fillBase_r <= fillBaseNext_s;
      issueCnt_r <= issueCntNext_s;
      recvCnt_r  <= recvCntNext_s;
    end
  end

  // Arbitration, fill sequencing and memory/cache strobes
  always_comb begin
    stateNext_s    = state_r;
    reqDNext_s     = reqD_r;
    fillBaseNext_s = fillBase_r;
    issueCntNext_s = issueCnt_r;
    recvCntNext_s  = recvCnt_r;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 16'h0000;
    fill_we_i = 1'b0;
    fill_we_d = 1'b0;
    fill_word = 3'd0;
    fill_data = 16'h0000;
    tag_we_i  = 1'b0;
    tag_we_d  = 1'b0;
    wr_done   = 1'b0;
    case (state_r)
      IDLE: begin
        issueCntNext_s = '0;
        recvCntNext_s  = '0;
        // Stores first, then D misses (older instruction), then I misses
        if (d_wr) begin
          stateNext_s = WRITE;
        end else if (d_miss) begin
          stateNext_s    = FILL;
          reqDNext_s     = 1'b1;
          fillBaseNext_s = d_miss_addr & ~BLOCK_MASK;
        end else if (i_miss) begin
          stateNext_s    = FILL;
          reqDNext_s     = 1'b0;
          fillBaseNext_s = i_miss_addr & ~BLOCK_MASK;
        end else begin
          stateNext_s = IDLE;
        end
      end
      FILL: begin
        if (issueCnt_r < CNT_FULL) begin
          mem_en         = 1'b1;
          mem_addr       = fillBase_r + ADDR_W'({issueCnt_r, 1'b0});
          issueCntNext_s = issueCnt_r + (IDX_W+1)'(1);
        end else begin
          issueCntNext_s = issueCnt_r;
        end
        if (mem_rvalid) begin
          fill_we_i     = ~reqD_r;
          fill_we_d     = reqD_r;
          fill_word     = 3'(recvCnt_r[IDX_W-1:0]);
          fill_data     = mem_rdata;
          recvCntNext_s = recvCnt_r + (IDX_W+1)'(1);
          if (recvCnt_r == CNT_LAST) begin
            tag_we_i    = ~reqD_r;
            tag_we_d    = reqD_r;
            stateNext_s = IDLE;
          end else begin
            stateNext_s = FILL;
          end
        end else begin
          recvCntNext_s = recvCnt_r;
        end
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_wdata   = d_wr_data;
        wr_done     = 1'b1;
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  assign fill_base = fillBase_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed and randomized bench for cache_fill_ctrl: a latency-configurable memory model
// returns address-derived data; fills and stores are checked against timing rules.
module tb_cache_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d, wr_done, busy;
  logic [2:0]  fill_word;
  logic [15:0] fill_data, fill_base;

  int          nAsserts = 0;
  int          nFail    = 0;
  int          memLat   = 4;
  int          nStores  = 0;
  int          nWrDone  = 0;
  bit          stray    = 1'b0;
  logic [15:0] seed;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;
  ret_t pend[$];

  cache_fill_ctrl #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d), .fill_word(fill_word), .fill_data(fill_data),
    .tag_we_i(tag_we_i), .tag_we_d(tag_we_d), .fill_base(fill_base),
    .wr_done(wr_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memData(input logic [15:0] a);
    return (a * 16'h9E37) ^ seed;
  endfunction

  // Memory: a read accepted in cycle c returns its data during cycle c+memLat
  initial begin
    int cyc = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = stray;
      mem_rdata  = stray ? 16'hDEAD : 16'h0000;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend[0].data;
        void'(pend.pop_front());
      end
      if (mem_en === 1'b1 && mem_wr === 1'b0)
        pend.push_back('{cyc + memLat, memData(mem_addr)});
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (wr_done === 1'b1) nWrDone++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_fill_we"}, 32'({fill_we_i, fill_we_d}), 32'd0);
    chk({tag, "_tag_we"}, 32'({tag_we_i, tag_we_d}), 32'd0);
    chk({tag, "_wr_done"}, 32'(wr_done), 32'd0);
  endtask

  // Called at the first FILL cycle; walks every cycle of the fill, ends on the following IDLE cycle
  task automatic checkFill(input bit isD, input logic [15:0] addr, input int injectAt, input int abortAt);
    logic [15:0] base = {addr[15:4], 4'h0};
    int lat = memLat;
    for (int c = 0; c < 8 + lat; c++) begin
      bit expEn  = (c < 8);
      bit expWe  = (c >= lat);
      bit expTag = (c == 7 + lat);
      int k      = c - lat;
      chk("fill_busy", 32'(busy), 32'd1);
      chk("fill_mem_en", 32'(mem_en), 32'(expEn));
      chk("fill_mem_wr", 32'(mem_wr), 32'd0);
      if (expEn) chk("fill_mem_addr", 32'(mem_addr), 32'(base + 16'(2 * c)));
      chk("fill_we_i", 32'(fill_we_i), 32'(expWe && !isD));
      chk("fill_we_d", 32'(fill_we_d), 32'(expWe && isD));
      if (expWe) begin
        chk("fill_word", 32'(fill_word), 32'(k));
        chk("fill_data", 32'(fill_data), 32'(memData(base + 16'(2 * k))));
      end
      chk("tag_we_i", 32'(tag_we_i), 32'(expTag && !isD));
      chk("tag_we_d", 32'(tag_we_d), 32'(expTag && isD));
      chk("fill_base", 32'(fill_base), 32'(base));
      chk("fill_wr_done", 32'(wr_done), 32'd0);
      if (c == injectAt) begin
        d_wr = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
        i_miss = 1'b1; i_miss_addr = 16'h0A08;
        nStores++;
      end
      if (c == abortAt) begin
        rst_n = 1'b0;
        return;
      end
      if (expTag) begin
        if (isD) d_miss = 1'b0;
        else     i_miss = 1'b0;
      end
      tick();
    end
    chkIdle("after_fill");
  endtask

  // Called at the WRITE cycle; releases the store and ends on the following IDLE cycle
  task automatic checkWrite();
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_mem_en", 32'(mem_en), 32'd1);
    chk("wr_mem_wr", 32'(mem_wr), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'(d_wr_addr));
    chk("wr_mem_wdata", 32'(mem_wdata), 32'(d_wr_data));
    chk("wr_done", 32'(wr_done), 32'd1);
    chk("wr_fill_we", 32'({fill_we_i, fill_we_d, tag_we_i, tag_we_d}), 32'd0);
    d_wr = 1'b0;
    tick();
    chk("wr_after_busy", 32'(busy), 32'd0);
    chk("wr_after_done", 32'(wr_done), 32'd0);
  endtask

  initial begin
    seed = 16'($urandom);
    rst_n = 1'b0;
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    d_miss = 1'b0; d_miss_addr = 16'h0000;
    d_wr = 1'b0; d_wr_addr = 16'h0000; d_wr_data = 16'h0000;

    // Reset held two cycles with a miss pending: everything quiet
    for (int r = 0; r < 2; r++) begin
      tick();
      chkIdle("reset");
      chk("reset_mem_wr", 32'(mem_wr), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("reset_fill_base", 32'(fill_base), 32'd0);
      chk("reset_fill_word", 32'(fill_word), 32'd0);
      chk("reset_fill_data", 32'(fill_data), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    checkFill(1'b0, 16'h1236, -1, -1);

    // Simultaneous misses: D first, one IDLE cycle, then I
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h8008;
    tick();
    checkFill(1'b1, 16'h8008, -1, -1);
    tick();
    checkFill(1'b0, 16'h0040, -1, -1);

    // Store and I miss raised mid-fill: store goes first after the D fill
    d_miss = 1'b1; d_miss_addr = 16'h5010;
    tick();
    checkFill(1'b1, 16'h5010, 3, -1);
    tick();
    checkWrite();
    tick();
    checkFill(1'b0, 16'h0A08, -1, -1);

    // Reset after five words received: no tag, late returns ignored, refetch from word 0
    d_miss = 1'b1; d_miss_addr = 16'h7006;
    tick();
    checkFill(1'b1, 16'h7006, -1, 4 + 4);
    tick();
    chkIdle("midrst");
    rst_n = 1'b1;
    d_miss = 1'b0;
    for (int s = 0; s < 8; s++) begin
      stray = (s >= 4 && s < 6);
      tick();
      chkIdle("stray");
    end
    stray = 1'b0;
    d_miss = 1'b1;
    tick();
    checkFill(1'b1, 16'h7006, -1, -1);

    // Latency sweep on the same D miss
    memLat = 1;
    d_miss = 1'b1; d_miss_addr = 16'h9ABC;
    tick();
    checkFill(1'b1, 16'h9ABC, -1, -1);
    memLat = 7;
    d_miss = 1'b1;
    tick();
    checkFill(1'b1, 16'h9ABC, -1, -1);

    // Random mix of stores, misses and store+miss collisions
    for (int it = 0; it < 16; it++) begin
      int          kind   = int'($urandom_range(0, 2));
      bit          doStore = (kind != 2);
      bit          doMiss  = (kind != 0);
      bit          side    = 1'($urandom_range(0, 1));
      logic [15:0] a       = 16'($urandom);
      memLat = int'($urandom_range(1, 7));
      if (doMiss) begin
        if (side) begin d_miss = 1'b1; d_miss_addr = a; end
        else      begin i_miss = 1'b1; i_miss_addr = a; end
      end
      if (doStore) begin
        d_wr = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
        nStores++;
      end
      tick();
      if (doStore) begin
        checkWrite();
        if (doMiss) tick();
      end
      if (doMiss) checkFill(side, a, -1, -1);
    end

    tick();
    chk("wr_done_count", 32'(nWrDone), 32'(nStores));
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
